mem_arbiter_rr: RTL and testbench

//  Parametrised N-core shared-memory arbiter, next generation of the videocard's 4-core arbiter.

---
 rtl/videocard_pkg.sv | 20 ++
 rtl/rr_pick.sv | 41 ++++
 rtl/mem_arbiter_rr.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/videocard_pkg.sv
// Shared types and width helpers for the videocard memory arbiter.
package videocard_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  function automatic int core_idx_width(input int core_num);
    return (core_num > 1) ? $clog2(core_num) : 1;
  endfunction

  // Wide enough to hold READ_LATENCY-1 down to zero.
  function automatic int lat_cnt_width(input int read_latency);
    return (read_latency > 1) ? $clog2(read_latency + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner select: rotate the request vector past the last grant, priority-encode, unrotate.
// Build option ARB_FIXED_PRIO_EN: lowest set index wins and last_idx is ignored.
module rr_pick
  import videocard_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_idx,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  logic [N-1:0] rot;

  always_comb begin
    int start;
    int pick;
    valid  = 1'b0;
    winner = '0;
    pick   = 0;
`ifdef ARB_FIXED_PRIO_EN
    start  = 0;
`else
    start  = (int'(last_idx) + 1) % N;
`endif
    for (int k = 0; k < N; k++) begin
      rot[k] = req[(start + k) % N];
    end
    // Scan downward so the lowest rotated position is the one that sticks.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid = 1'b1;
        pick  = k;
      end
    end
    winner = IDX_W'((start + pick) % N);
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-core arbiter in front of the single-port video RAM: one access at a time, round-robin grant.
// Build option ARB_FIXED_PRIO_EN switches the winner select to fixed lowest-index priority.
module mem_arbiter_rr
  import videocard_pkg::*;
#(
  parameter int CORE_NUM     = 4,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CORE_NUM-1:0]          request,
  input  logic [CORE_NUM-1:0]          wren_core,
  input  logic [CORE_NUM*ADDR_W-1:0]   core_address,
  input  logic [CORE_NUM*DATA_W-1:0]   core_wdata,
  output logic [CORE_NUM*DATA_W-1:0]   core_rdata,
  output logic [CORE_NUM-1:0]          response,
  output logic [ADDR_W-1:0]            mem_address,
  output logic [DATA_W-1:0]            mem_data_write,
  output logic                         mem_wren,
  input  logic [DATA_W-1:0]            mem_data_read,
  output logic                         busy,
  output logic [$clog2(CORE_NUM)-1:0]  grant_idx
);

  localparam int CORE_IDX_W = core_idx_width(CORE_NUM);
  localparam int CNT_W      = lat_cnt_width(READ_LATENCY);

  arb_state_t                 state_q, state_d;
  logic [CORE_IDX_W-1:0]      last_grant_q, last_grant_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       write_q, write_d;
  logic [ADDR_W-1:0]          mem_address_q, mem_address_d;
  logic [DATA_W-1:0]          mem_data_write_q, mem_data_write_d;
  logic                       mem_wren_q, mem_wren_d;
  logic [CORE_NUM*DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [CORE_NUM-1:0]        response_q, response_d;
  logic [CORE_NUM-1:0]        resp_mask_q;

  logic [CORE_NUM-1:0]        eligible;
  logic                       pick_valid;
  logic [CORE_IDX_W-1:0]      pick_idx;

  // A core just served sits out one arbitration so the others get a look in.
  assign eligible = request & ~resp_mask_q;

  rr_pick #(
    .N     (CORE_NUM),
    .IDX_W (CORE_IDX_W)
  ) u_pick (
    .req      (eligible),
    .last_idx (last_grant_q),
    .valid    (pick_valid),
    .winner   (pick_idx)
  );

  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    cnt_d            = cnt_q;
    write_d          = write_q;
    mem_address_d    = mem_address_q;
    mem_data_write_d = mem_data_write_q;
    mem_wren_d       = mem_wren_q;
    core_rdata_d     = core_rdata_q;
    response_d       = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          last_grant_d     = pick_idx;
          mem_address_d    = core_address[pick_idx*ADDR_W +: ADDR_W];
          mem_data_write_d = core_wdata[pick_idx*DATA_W +: DATA_W];
          mem_wren_d       = wren_core[pick_idx];
          write_d          = wren_core[pick_idx];
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        mem_wren_d = 1'b0;
        if (write_q) begin
          response_d[last_grant_q] = 1'b1;
          state_d                  = RESP;
        end else begin
          cnt_d   = CNT_W'(READ_LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          core_rdata_d[last_grant_q*DATA_W +: DATA_W] = mem_data_read;
          response_d[last_grant_q]                    = 1'b1;
          state_d                                     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      last_grant_q     <= CORE_IDX_W'(CORE_NUM - 1);
      cnt_q            <= '0;
      write_q          <= 1'b0;
      mem_address_q    <= '0;
      mem_data_write_q <= '0;
      mem_wren_q       <= 1'b0;
      core_rdata_q     <= '0;
      response_q       <= '0;
      resp_mask_q      <= '0;
    end else begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      cnt_q            <= cnt_d;
      write_q          <= write_d;
      mem_address_q    <= mem_address_d;
      mem_data_write_q <= mem_data_write_d;
      mem_wren_q       <= mem_wren_d;
      core_rdata_q     <= core_rdata_d;
      response_q       <= response_d;
      resp_mask_q      <= response_q;
    end
  end

  assign core_rdata     = core_rdata_q;
  assign response       = response_q;
  assign mem_address    = mem_address_q;
  assign mem_data_write = mem_data_write_q;
  assign mem_wren       = mem_wren_q;
  assign busy           = (state_q != IDLE);
  assign grant_idx      = last_grant_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed scoreboard bench for mem_arbiter_rr: a 4-core READ_LATENCY=2 instance and an 8-core READ_LATENCY=1 instance.
// With ARB_FIXED_PRIO_EN defined the fixed-priority sequence replaces the round-robin sequence.
module tb_mem_arbiter_rr;

  localparam int N   = 4;
  localparam int RL  = 2;
  localparam int N8  = 8;
  localparam int RL8 = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]    request, wren_core, response;
  logic [N*32-1:0] core_address, core_wdata, core_rdata;
  logic [31:0]     mem_address, mem_data_write, mem_data_read;
  logic            mem_wren, busy;
  logic [1:0]      grant_idx;

  logic [N8-1:0]    request8, wren8, response8;
  logic [N8*32-1:0] address8, wdata8, rdata8;
  logic [31:0]      mem_address8, mem_data_write8, mem_data_read8;
  logic             mem_wren8, busy8;
  logic [2:0]       grant_idx8;

  mem_arbiter_rr #(.CORE_NUM(N), .DATA_W(32), .ADDR_W(32), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset), .request(request), .wren_core(wren_core),
    .core_address(core_address), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .response(response), .mem_address(mem_address), .mem_data_write(mem_data_write),
    .mem_wren(mem_wren), .mem_data_read(mem_data_read), .busy(busy), .grant_idx(grant_idx)
  );

  mem_arbiter_rr #(.CORE_NUM(N8), .DATA_W(32), .ADDR_W(32), .READ_LATENCY(RL8)) dut8 (
    .clk(clk), .reset(reset), .request(request8), .wren_core(wren8),
    .core_address(address8), .core_wdata(wdata8), .core_rdata(rdata8),
    .response(response8), .mem_address(mem_address8), .mem_data_write(mem_data_write8),
    .mem_wren(mem_wren8), .mem_data_read(mem_data_read8), .busy(busy8), .grant_idx(grant_idx8)
  );

  // Memory contents are a fixed function of address; data only appears RL cycles after the address.
  function automatic logic [31:0] mem_value(input logic [31:0] a);
    if (a == 32'h10) return 32'hCAFE_0001;
    return {16'hD00D, a[15:0]} ^ 32'h0000_5A5A;
  endfunction

  logic [31:0] apipe [RL];
  always @(posedge clk) begin
    apipe[0] <= mem_address;
    for (int k = 1; k < RL; k++) apipe[k] <= apipe[k-1];
  end
  assign mem_data_read = mem_value(apipe[RL-1]);

  logic [31:0] apipe8;
  always @(posedge clk) apipe8 <= mem_address8;
  assign mem_data_read8 = mem_value(apipe8);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          core;
    logic [31:0] data;
    bit          is_read;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_rdata [N];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          t0;

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int core, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input int due);
    exp_t e;
    request[core]              = 1'b1;
    wren_core[core]            = wr;
    core_address[core*32 +: 32] = addr;
    core_wdata[core*32 +: 32]   = wdata;
    e.core    = core;
    e.data    = wr ? wdata : mem_value(addr);
    e.is_read = !wr;
    e.due     = due;
    sb.push_back(e);
  endtask

  task automatic pushExpected(input int core, input logic [31:0] addr);
    exp_t e;
    e.core = core; e.data = mem_value(addr); e.is_read = 1'b1; e.due = -1;
    sb.push_back(e);
  endtask

  task automatic clearModel();
    for (int i = 0; i < N; i++) model_rdata[i] = '0;
  endtask

  // Wait (bounded) for a response pulse on the 4-core DUT, then pop and compare against the scoreboard.
  task automatic waitResponse(input logic [N-1:0] drop);
    exp_t            e;
    logic [N*32-1:0] flat;
    int              n = 0;
    while (response == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("resp_seen", 256'(|response), 256'(1));
    if (response == '0) return;
    if (sb.size() == 0) begin
      checkOutput("sb_nonempty", 256'(response), 256'(0));
      return;
    end
    e = sb.pop_front();
    checkOutput("resp_core", 256'(response), 256'(4'b0001 << e.core));
    checkOutput("grant_idx", 256'(grant_idx), 256'(e.core));
    checkOutput("mem_wren_resp", 256'(mem_wren), 256'(0));
    if (e.due >= 0) checkOutput("resp_cycle", 256'(cyc - t0), 256'(e.due));
    if (e.is_read) model_rdata[e.core] = e.data;
    for (int i = 0; i < N; i++) flat[i*32 +: 32] = model_rdata[i];
    checkOutput("core_rdata", 256'(core_rdata), 256'(flat));
    request = request & ~drop;
    @(negedge clk);
    checkOutput("resp_one_cycle", 256'(response), 256'(0));
  endtask

  task automatic waitResponse8();
    int n = 0;
    while (response8 == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("resp8_seen", 256'(|response8), 256'(1));
  endtask

  initial begin
    reset = 1'b1;
    request = '0; wren_core = '0; core_address = '0; core_wdata = '0;
    request8 = '0; wren8 = '0; address8 = '0; wdata8 = '0;
    clearModel();
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("rst_mem_address", 256'(mem_address), 256'(0));
    checkOutput("rst_mem_wdata", 256'(mem_data_write), 256'(0));
    checkOutput("rst_mem_wren", 256'(mem_wren), 256'(0));
    checkOutput("rst_busy", 256'(busy), 256'(0));
    checkOutput("rst_response", 256'(response), 256'(0));
    checkOutput("rst_core_rdata", 256'(core_rdata), 256'(0));
    checkOutput("rst_grant_idx", 256'(grant_idx), 256'(N - 1));
    checkOutput("rst_grant_idx8", 256'(grant_idx8), 256'(N8 - 1));
    reset = 1'b0;
    @(negedge clk);

    // Single read by core1; address change and request drop after grant are ignored
    $display("[TB] single read core1");
    applyStimulus(1, 1'b0, 32'h10, 32'h0, RL + 2);
    t0 = cyc;
    @(negedge clk);
    checkOutput("rd_issue_addr", 256'(mem_address), 256'(32'h10));
    checkOutput("rd_issue_wren", 256'(mem_wren), 256'(0));
    checkOutput("rd_issue_busy", 256'(busy), 256'(1));
    checkOutput("rd_issue_grant", 256'(grant_idx), 256'(1));
    core_address[1*32 +: 32] = 32'h44;
    request[1] = 1'b0;
    @(negedge clk);
    checkOutput("rd_wait_addr", 256'(mem_address), 256'(32'h10));
    waitResponse('0);

    // Single write by core2
    $display("[TB] single write core2");
    applyStimulus(2, 1'b1, 32'h20, 32'h1234_5678, 2);
    t0 = cyc;
    @(negedge clk);
    checkOutput("wr_issue_wren", 256'(mem_wren), 256'(1));
    checkOutput("wr_issue_addr", 256'(mem_address), 256'(32'h20));
    checkOutput("wr_issue_data", 256'(mem_data_write), 256'(32'h1234_5678));
    request[2] = 1'b0;
    wren_core[2] = 1'b0;
    waitResponse('0);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clearModel();
`ifdef ARB_FIXED_PRIO_EN
    // Cores 0 and 2 held: core0 wins except in the masked cycle after its own response
    $display("[TB] fixed priority cores 0,2");
    applyStimulus(0, 1'b0, 32'h200, 32'h0, -1);
    applyStimulus(2, 1'b0, 32'h208, 32'h0, -1);
    pushExpected(0, 32'h200);
    pushExpected(2, 32'h208);
    t0 = cyc;
    waitResponse('0);
    waitResponse('0);
    waitResponse('0);
    waitResponse(4'h5);
`else
    // All four read from reset: order 0,1,2,3,0
    $display("[TB] four-way round robin");
    for (int i = 0; i < N; i++) applyStimulus(i, 1'b0, 32'h100 + 32'(i * 4), 32'h0, -1);
    pushExpected(0, 32'h100);
    t0 = cyc;
    for (int i = 0; i < N; i++) waitResponse('0);
    waitResponse(4'hF);
`endif

    // Reset during WAIT of a core3 read aborts it
    $display("[TB] reset during wait");
    request[3] = 1'b1;
    wren_core[3] = 1'b0;
    core_address[3*32 +: 32] = 32'h300;
    t0 = cyc;
    @(negedge clk);
    checkOutput("abort_grant", 256'(grant_idx), 256'(3));
    @(negedge clk);
    checkOutput("abort_busy_wait", 256'(busy), 256'(1));
    reset = 1'b1;
    request[3] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    clearModel();
    checkOutput("abort_busy", 256'(busy), 256'(0));
    checkOutput("abort_wren", 256'(mem_wren), 256'(0));
    checkOutput("abort_resp", 256'(response), 256'(0));
    checkOutput("abort_grant_rst", 256'(grant_idx), 256'(N - 1));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("abort_no_resp", 256'(response), 256'(0));
    end
    applyStimulus(0, 1'b0, 32'h400, 32'h0, RL + 2);
    applyStimulus(2, 1'b0, 32'h408, 32'h0, -1);
    t0 = cyc;
    @(negedge clk);
    checkOutput("post_abort_grant", 256'(grant_idx), 256'(0));
    waitResponse(4'h1);
    waitResponse(4'h4);

    // 8-core instance: core7 then core0, pointer wraps 7->0, read response at cycle 3
    $display("[TB] 8-core wrap");
    request8[7] = 1'b1;
    address8[7*32 +: 32] = 32'h70;
    t0 = cyc;
    waitResponse8();
    checkOutput("w8_resp7", 256'(response8), 256'(8'h80));
    checkOutput("w8_cycle7", 256'(cyc - t0), 256'(RL8 + 2));
    checkOutput("w8_grant7", 256'(grant_idx8), 256'(7));
    checkOutput("w8_rdata7", 256'(rdata8[7*32 +: 32]), 256'(mem_value(32'h70)));
    request8[7] = 1'b0;
    @(negedge clk);
    request8[0] = 1'b1;
    address8[0*32 +: 32] = 32'h80;
    t0 = cyc;
    waitResponse8();
    checkOutput("w8_resp0", 256'(response8), 256'(8'h01));
    checkOutput("w8_cycle0", 256'(cyc - t0), 256'(RL8 + 2));
    checkOutput("w8_grant0", 256'(grant_idx8), 256'(0));
    checkOutput("w8_rdata0", 256'(rdata8[0*32 +: 32]), 256'(mem_value(32'h80)));
    checkOutput("w8_rdata7_hold", 256'(rdata8[7*32 +: 32]), 256'(mem_value(32'h70)));
    request8[0] = 1'b0;
    @(negedge clk);

    checkOutput("sb_drained", 256'(sb.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
